// File: rtl/load_store_unit.sv
// Load/store access unit for a word-organised data memory with combinational reads.
// Optional misalignment trapping is enabled by defining LSU_MISALIGN_TRAP_EN.
module load_store_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [9:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [9:0]  mem_ReadAddr,
    output logic [9:0]  mem_WriteAddr,
    output logic [31:0] mem_DataIn,
    output logic        mem_regWE,
    input  logic [31:0] mem_DataOut
);
    typedef enum logic [1:0] {IDLE, LOAD, STORE} state_t;

    state_t      state;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [9:0]  addr_q;
    logic [31:0] wdata_q;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_data;
    logic [31:0] merge_data;
    logic        misalign;

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign = (size_q == 2'b01) ? addr_q[0] :
                      (size_q[1]        ? (addr_q[1:0] != 2'b00) : 1'b0);
`else
    assign misalign = 1'b0;
`endif

    assign req_ready = (state == IDLE);

    always_comb begin
        byte_lane = mem_DataOut[7:0];
        case (addr_q[1:0])
            2'b01:   byte_lane = mem_DataOut[15:8];
            2'b10:   byte_lane = mem_DataOut[23:16];
            2'b11:   byte_lane = mem_DataOut[31:24];
            default: byte_lane = mem_DataOut[7:0];
        endcase
        half_lane = addr_q[1] ? mem_DataOut[31:16] : mem_DataOut[15:0];
    end

    always_comb begin
        load_data = mem_DataOut;
        case (size_q)
            2'b00:   load_data = {{24{signed_q & byte_lane[7]}}, byte_lane};
            2'b01:   load_data = {{16{signed_q & half_lane[15]}}, half_lane};
            default: load_data = mem_DataOut;
        endcase
    end

    // Sub-word stores keep the untouched lanes from the current memory word.
    always_comb begin
        merge_data = mem_DataOut;
        case (size_q)
            2'b00: begin
                case (addr_q[1:0])
                    2'b01:   merge_data[15:8]  = wdata_q[7:0];
                    2'b10:   merge_data[23:16] = wdata_q[7:0];
                    2'b11:   merge_data[31:24] = wdata_q[7:0];
                    default: merge_data[7:0]   = wdata_q[7:0];
                endcase
            end
            2'b01: begin
                if (addr_q[1])
                    merge_data[31:16] = wdata_q[15:0];
                else
                    merge_data[15:0] = wdata_q[15:0];
            end
            default: merge_data = wdata_q;
        endcase
    end

    always_comb begin
        mem_ReadAddr  = '0;
        mem_WriteAddr = '0;
        mem_DataIn    = '0;
        mem_regWE     = 1'b0;
        if (state != IDLE) begin
            mem_ReadAddr  = {addr_q[9:2], 2'b00};
            mem_WriteAddr = {addr_q[9:2], 2'b00};
        end
        if (state == STORE) begin
            mem_DataIn = merge_data;
            mem_regWE  = ~reset & ~misalign;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            size_q     <= '0;
            signed_q   <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        size_q   <= req_size;
                        signed_q <= req_signed;
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        state    <= req_write ? STORE : LOAD;
                    end
                end
                LOAD: begin
                    resp_valid <= 1'b1;
                    resp_rdata <= misalign ? 32'h0 : load_data;
                    resp_err   <= misalign;
                    state      <= IDLE;
                end
                STORE: begin
                    resp_valid <= 1'b1;
                    resp_rdata <= 32'h0;
                    resp_err   <= misalign;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
